// File: rtl/tcp_vlg_rx_queue.sv
// In-order TCP receive queue: accepts only the next expected segment, buffers it
// speculatively, commits on a clean end-of-segment and streams committed bytes out.
module tcp_vlg_rx_queue #(
  parameter int unsigned RAM_DEPTH       = 12,
  parameter int unsigned MAX_PAYLOAD_LEN = 1400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        connected,
  input  logic        init,
  input  logic [31:0] init_ack,
  input  logic [7:0]  in_d,
  input  logic        in_v,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic        in_err,
  input  logic [31:0] in_seq,
  input  logic [15:0] in_len,
  output logic [31:0] loc_ack,
  output logic        ack_pend,
  input  logic        ack_sent,
  output logic        dup,
  output logic [15:0] win,
  output logic [7:0]  dout,
  output logic        vout
);

  typedef enum logic [1:0] {IDLE, WRITE, DROP, COMMIT} state_t;

  localparam logic [RAM_DEPTH-1:0] PTR_ONE = {{(RAM_DEPTH-1){1'b0}}, 1'b1};

  state_t               state_q;
  logic [RAM_DEPTH-1:0] wr_spec_q, wr_com_q, rd_q;
  logic [15:0]          cnt_q, len_q;
  logic                 seq_bad_q;
  logic [31:0]          loc_ack_q;
  logic                 ack_pend_q, dup_q, vout_q;
  logic [7:0]           dout_q;
  logic [7:0]           ram [2**RAM_DEPTH];

  logic [RAM_DEPTH-1:0] used, free;
  logic [31:0]          free_w;
  logic [15:0]          win_c;
  logic [15:0]          cnt_nx;
  logic                 seq_ok, len_ok, accept, ram_we;

  // Free space counts against the speculative pointer so an in-flight segment
  // can never be overwritten by the next one.
  always_comb begin
    used   = wr_spec_q - rd_q;
    free   = ~used;
    free_w = 32'(free);
    win_c  = (free_w > 32'h0000_FFFF) ? 16'hFFFF : free_w[15:0];
  end

  always_comb begin
    seq_ok = (in_seq == loc_ack_q);
    len_ok = (in_len != '0) && ({16'h0, in_len} <= MAX_PAYLOAD_LEN) && (in_len <= win_c);
    accept = seq_ok && len_ok;
    cnt_nx = cnt_q + 16'd1;
  end

  always_comb begin
    ram_we = 1'b0;
    if (rst && connected && !init && in_v) begin
      case (state_q)
        IDLE:    ram_we = in_sof && accept;
        WRITE:   ram_we = (cnt_q != len_q);
        default: ram_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_spec_q] <= in_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_spec_q  <= '0;
      wr_com_q   <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      seq_bad_q  <= 1'b0;
      loc_ack_q  <= '0;
      ack_pend_q <= 1'b0;
      dup_q      <= 1'b0;
      vout_q     <= 1'b0;
      dout_q     <= '0;
    end else begin
      dup_q  <= 1'b0;
      vout_q <= 1'b0;
      if (init) begin
        loc_ack_q <= init_ack;
        wr_spec_q <= '0;
        wr_com_q  <= '0;
        rd_q      <= '0;
        state_q   <= IDLE;
      end else if (!connected) begin
        wr_spec_q  <= '0;
        wr_com_q   <= '0;
        rd_q       <= '0;
        state_q    <= IDLE;
        ack_pend_q <= 1'b0;
      end else begin
        if (rd_q != wr_com_q) begin
          vout_q <= 1'b1;
          dout_q <= ram[rd_q];
          rd_q   <= rd_q + PTR_ONE;
        end

        if (ack_sent) ack_pend_q <= 1'b0;

        case (state_q)
          IDLE: begin
            if (in_v && in_sof) begin
              len_q <= in_len;
              if (in_len == '0) begin
                dup_q <= ~seq_ok;
              end else if (accept) begin
                cnt_q <= 16'd1;
                // The sof byte is payload; a one-byte segment may end here too.
                if (in_eof) begin
                  if (!in_err && in_len == 16'd1) begin
                    wr_spec_q <= wr_spec_q + PTR_ONE;
                    state_q   <= COMMIT;
                  end else begin
                    wr_spec_q <= wr_com_q;
                  end
                end else begin
                  wr_spec_q <= wr_spec_q + PTR_ONE;
                  state_q   <= WRITE;
                end
              end else begin
                seq_bad_q <= ~seq_ok;
                if (in_eof) dup_q <= ~seq_ok;
                else        state_q <= DROP;
              end
            end
          end

          WRITE: begin
            if (in_v) begin
              if (cnt_q == len_q) begin
                wr_spec_q <= wr_com_q;
                state_q   <= IDLE;
              end else if (in_eof) begin
                if (!in_err && cnt_nx == len_q) begin
                  wr_spec_q <= wr_spec_q + PTR_ONE;
                  cnt_q     <= cnt_nx;
                  state_q   <= COMMIT;
                end else begin
                  wr_spec_q <= wr_com_q;
                  state_q   <= IDLE;
                end
              end else begin
                wr_spec_q <= wr_spec_q + PTR_ONE;
                cnt_q     <= cnt_nx;
              end
            end
          end

          DROP: begin
            if (in_v && in_eof) begin
              dup_q   <= seq_bad_q;
              state_q <= IDLE;
            end
          end

          COMMIT: begin
            wr_com_q   <= wr_spec_q;
            loc_ack_q  <= loc_ack_q + {16'h0, len_q};
            ack_pend_q <= 1'b1;
            state_q    <= IDLE;
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign loc_ack  = loc_ack_q;
  assign ack_pend = ack_pend_q;
  assign dup      = dup_q;
  assign win      = win_c;
  assign dout     = dout_q;
  assign vout     = vout_q;

endmodule

// File: tb/tb_tcp_vlg_rx_queue.sv
// Bench for tcp_vlg_rx_queue: a default-size instance and a 16-byte instance share
// the segment bus; each is enabled in turn through its own connected input.
module tb_tcp_vlg_rx_queue;

  logic        clk = 1'b0;
  logic        rst, conn_a, conn_b, init, ack_sent;
  logic [31:0] init_ack, in_seq;
  logic [7:0]  in_d;
  logic        in_v, in_sof, in_eof, in_err;
  logic [15:0] in_len;

  logic [31:0] loc_ack_a, loc_ack_b;
  logic        ack_pend_a, ack_pend_b, dup_a, dup_b, vout_a, vout_b;
  logic [15:0] win_a, win_b;
  logic [7:0]  dout_a, dout_b;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned dupc_a = 0;
  int unsigned dupc_b = 0;
  logic [7:0]  qa [$];
  logic [7:0]  qb [$];
  logic [7:0]  pay [$];

  always #5 clk = ~clk;

  tcp_vlg_rx_queue dut_a (
    .clk(clk), .rst(rst), .connected(conn_a), .init(init), .init_ack(init_ack),
    .in_d(in_d), .in_v(in_v), .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err),
    .in_seq(in_seq), .in_len(in_len), .loc_ack(loc_ack_a), .ack_pend(ack_pend_a),
    .ack_sent(ack_sent), .dup(dup_a), .win(win_a), .dout(dout_a), .vout(vout_a)
  );

  tcp_vlg_rx_queue #(.RAM_DEPTH(4), .MAX_PAYLOAD_LEN(1400)) dut_b (
    .clk(clk), .rst(rst), .connected(conn_b), .init(init), .init_ack(init_ack),
    .in_d(in_d), .in_v(in_v), .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err),
    .in_seq(in_seq), .in_len(in_len), .loc_ack(loc_ack_b), .ack_pend(ack_pend_b),
    .ack_sent(ack_sent), .dup(dup_b), .win(win_b), .dout(dout_b), .vout(vout_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vout_a) begin
      check("a_byte_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) check("a_byte", 32'(dout_a), 32'(qa.pop_front()));
    end
    if (vout_b) begin
      check("b_byte_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) check("b_byte", 32'(dout_b), 32'(qb.pop_front()));
    end
    if (dup_a) dupc_a++;
    if (dup_b) dupc_b++;
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    in_v = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0; in_d = '0;
  endtask

  task automatic fill(input logic [7:0] base, input int unsigned n);
    pay.delete();
    for (int unsigned i = 0; i < n; i++) pay.push_back(base + 8'(i));
  endtask

  // Drives pay[0..n-1] as one segment; accepted payload is queued for the monitor.
  task automatic send_seg(input logic [31:0] seq, input logic [15:0] len, input int unsigned n,
                          input logic err, input logic ok, input logic to_b);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_v = 1'b1; in_sof = (i == 0); in_eof = (i == n - 1);
      in_err = err && (i == n - 1); in_d = pay[i]; in_seq = seq; in_len = len;
    end
    @(posedge clk); #1;
    clear_bus();
    if (ok) foreach (pay[i]) begin
      if (to_b) qb.push_back(pay[i]);
      else      qa.push_back(pay[i]);
    end
  endtask

  task automatic pulse_init(input logic [31:0] v);
    init_ack = v; init = 1'b1;
    step(1);
    init = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned d0;
    rst = 1'b0; conn_a = 1'b1; conn_b = 1'b0; init = 1'b0; ack_sent = 1'b0;
    init_ack = '0; in_seq = '0; in_len = '0;
    clear_bus();
    step(3);
    @(negedge clk);
    check("rst_loc_ack", loc_ack_a, 32'h0);
    check("rst_ack_pend", 32'(ack_pend_a), 32'h0);
    check("rst_vout", 32'(vout_a), 32'h0);
    check("rst_dout", 32'(dout_a), 32'h0);
    check("rst_win_a", 32'(win_a), 32'd4095);
    check("rst_win_b", 32'(win_b), 32'd15);
    step(1);
    rst = 1'b1;
    step(1);

    // Basic in-order segment, bytes must stream on consecutive cycles.
    pulse_init(32'h0000_1000);
    pay.delete();
    pay.push_back(8'hAA); pay.push_back(8'hBB); pay.push_back(8'hCC); pay.push_back(8'hDD);
    send_seg(32'h0000_1000, 16'd4, 4, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && !vout_a; i++) @(negedge clk);
    check("first_vout", 32'(vout_a), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("vout_run", 32'(vout_a), 32'd1);
    end
    step(4);
    @(negedge clk);
    check("seg1_loc_ack", loc_ack_a, 32'h0000_1004);
    check("seg1_ack_pend", 32'(ack_pend_a), 32'd1);
    check("seg1_drained", qa.size(), 0);
    step(1);
    ack_sent = 1'b1;
    step(1);
    ack_sent = 1'b0;
    @(negedge clk);
    check("ack_sent_clr", 32'(ack_pend_a), 32'd0);

    // Old sequence number: dropped with exactly one dup pulse.
    d0 = dupc_a;
    fill(8'h10, 8);
    send_seg(32'h0000_0FF0, 16'd8, 8, 1'b0, 1'b0, 1'b0);
    step(4);
    @(negedge clk);
    check("dup_count", dupc_a - d0, 1);
    check("dup_loc_ack", loc_ack_a, 32'h0000_1004);

    // Checksum error on eof: nothing committed, window restored.
    d0 = dupc_a;
    fill(8'h20, 6);
    send_seg(32'h0000_1004, 16'd6, 6, 1'b1, 1'b0, 1'b0);
    step(4);
    @(negedge clk);
    check("err_loc_ack", loc_ack_a, 32'h0000_1004);
    check("err_win", 32'(win_a), 32'd4095);
    check("err_no_dup", dupc_a - d0, 0);

    // Early eof, oversize length and keepalives.
    fill(8'h30, 4);
    send_seg(32'h0000_1004, 16'd6, 4, 1'b0, 1'b0, 1'b0);
    fill(8'h40, 2);
    send_seg(32'h0000_1004, 16'd1401, 2, 1'b0, 1'b0, 1'b0);
    step(3);
    @(negedge clk);
    check("early_oversize_loc_ack", loc_ack_a, 32'h0000_1004);
    check("early_oversize_win", 32'(win_a), 32'd4095);
    check("oversize_no_dup", dupc_a - d0, 0);
    fill(8'h00, 1);
    send_seg(32'h0000_0FFF, 16'd0, 1, 1'b0, 1'b0, 1'b0);
    send_seg(32'h0000_1004, 16'd0, 1, 1'b0, 1'b0, 1'b0);
    step(2);
    @(negedge clk);
    check("keepalive_dup", dupc_a - d0, 1);
    check("keepalive_loc_ack", loc_ack_a, 32'h0000_1004);

    // Sequence number wraps through 2^32.
    pulse_init(32'hFFFF_FFFE);
    fill(8'h51, 4);
    send_seg(32'hFFFF_FFFE, 16'd4, 4, 1'b0, 1'b1, 1'b0);
    step(8);
    @(negedge clk);
    check("wrap_loc_ack", loc_ack_a, 32'h0000_0002);
    check("wrap_drained", qa.size(), 0);

    // Reset in the middle of a segment.
    fill(8'h61, 5);
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_v = 1'b1; in_sof = (i == 0); in_eof = 1'b0; in_d = pay[i];
      in_seq = 32'h0000_0002; in_len = 16'd5;
    end
    @(posedge clk); #1;
    clear_bus();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_loc_ack", loc_ack_a, 32'h0);
    check("mid_rst_ack_pend", 32'(ack_pend_a), 32'h0);
    check("mid_rst_dout", 32'(dout_a), 32'h0);
    check("mid_rst_vout", 32'(vout_a), 32'h0);
    check("mid_rst_dup", 32'(dup_a), 32'h0);
    check("mid_rst_win", 32'(win_a), 32'd4095);
    #1 rst = 1'b1;
    step(1);
    fill(8'h71, 3);
    send_seg(32'h0000_0000, 16'd3, 3, 1'b0, 1'b1, 1'b0);
    step(6);
    @(negedge clk);
    check("post_rst_loc_ack", loc_ack_a, 32'h0000_0003);
    check("post_rst_drained", qa.size(), 0);

    // Small buffer: full-window segment, then a 1-byte segment that does not fit.
    conn_a = 1'b0; conn_b = 1'b1;
    step(1);
    pulse_init(32'h0000_0100);
    fill(8'h81, 5);
    send_seg(32'h0000_0100, 16'd5, 5, 1'b0, 1'b1, 1'b1);
    step(8);
    d0 = dupc_b;
    fill(8'h90, 15);
    send_seg(32'h0000_0105, 16'd15, 15, 1'b0, 1'b1, 1'b1);
    step(1);
    in_v = 1'b1; in_sof = 1'b1; in_eof = 1'b1; in_d = 8'hEE;
    in_seq = 32'h0000_0114; in_len = 16'd1;
    @(negedge clk);
    check("full_win_b", 32'(win_b), 32'd0);
    check("full_loc_ack_b", loc_ack_b, 32'h0000_0114);
    step(1);
    clear_bus();
    step(20);
    @(negedge clk);
    check("full_no_dup", dupc_b - d0, 0);
    check("full_loc_ack_after", loc_ack_b, 32'h0000_0114);
    check("full_drained", qb.size(), 0);
    check("drain_win_b", 32'(win_b), 32'd15);
    fill(8'hA1, 3);
    send_seg(32'h0000_0114, 16'd3, 3, 1'b0, 1'b1, 1'b1);
    step(8);
    @(negedge clk);
    check("b_wrap_loc_ack", loc_ack_b, 32'h0000_0117);
    check("b_wrap_drained", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcp_vlg_rx_queue.md
TCP_VLG_RX_QUEUE -- requirements
Module: tcp_vlg_rx_queue

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 12: log2 of receive buffer size in bytes.
REQ-002 SHALL have parameter MAX_PAYLOAD_LEN, default 1400: largest segment payload accepted.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port connected, input, 1: connection established; low flushes the block.
REQ-006 SHALL have port init, input, 1: one-cycle pulse that loads the initial expected sequence number.
REQ-007 SHALL have port init_ack, input, 32: remote ISN+1, sampled with init.
REQ-008 SHALL have port in_d, input, 8: payload byte.
REQ-009 SHALL have port in_v, input, 1: in_d valid.
REQ-010 SHALL have port in_sof, input, 1: first payload byte, or a zero-length segment when in_len=0.
REQ-011 SHALL have port in_eof, input, 1: last payload byte.
REQ-012 SHALL have port in_err, input, 1: checksum or framing error, valid with in_eof.
REQ-013 SHALL have port in_seq, input, 32: segment sequence number, valid with in_sof.
REQ-014 SHALL have port in_len, input, 16: segment payload length, valid with in_sof.
REQ-015 SHALL have port loc_ack, output, 32: next expected sequence number (ack number to send).
REQ-016 SHALL have port ack_pend, output, 1: an accepted segment awaits acknowledgement.
REQ-017 SHALL have port ack_sent, input, 1: pulse that clears ack_pend.
REQ-018 SHALL have port dup, output, 1: one-cycle pulse when a segment is rejected as out-of-order or duplicate.
REQ-019 SHALL have port win, output, 16: free buffer bytes for the advertised window.
REQ-020 SHALL have port dout, output, 8: in-order delivered byte.
REQ-021 SHALL have port vout, output, 1: dout valid; there is no backpressure.

Function
REQ-022 SHALL buffer bytes in a 2^RAM_DEPTH-byte circular RAM with wr_spec, wr_com and rd pointers of RAM_DEPTH bits that wrap modulo 2^RAM_DEPTH.
REQ-023 SHALL implement FSM states IDLE, WRITE, DROP and COMMIT.
REQ-024 SHALL go IDLE->WRITE on in_sof&in_v when connected, in_seq==loc_ack, 0<in_len<=MAX_PAYLOAD_LEN and in_len<=win; otherwise it SHALL go IDLE->DROP.
REQ-025 SHALL write each valid byte in WRITE at wr_spec, increment wr_spec, and count the bytes.
REQ-026 SHALL go WRITE->COMMIT on in_eof&in_v when in_err=0 and the byte count equals in_len.
REQ-027 SHALL in COMMIT, for one cycle, set wr_com=wr_spec, loc_ack=loc_ack+in_len (mod 2^32) and ack_pend=1, then return to IDLE.
REQ-028 SHALL on in_err=1, count mismatch or in_eof early/late, restore wr_spec=wr_com, leave loc_ack unchanged and go to IDLE.
REQ-029 SHALL stay in DROP until in_eof&in_v, then return to IDLE, pulsing dup once when the rejection cause is in_seq!=loc_ack.
REQ-030 SHALL treat in_sof with in_len=0 as a single-cycle segment: no buffer change, dup pulse if in_seq!=loc_ack (keepalive probe), otherwise no action.
REQ-031 SHALL compute win = 2^RAM_DEPTH-1-(wr_spec-rd) mod 2^RAM_DEPTH, saturated to 16'hFFFF.
REQ-032 SHALL drive vout=1 with RAM[rd] on the cycle after rd!=wr_com is seen and advance rd, giving one byte per cycle and a read latency of 2 cycles from commit to first vout.
REQ-033 SHALL never deliver uncommitted bytes, and SHALL give ack_sent priority over setting ack_pend when both coincide only if no COMMIT occurs that cycle; COMMIT wins.
REQ-034 SHALL on init load loc_ack=init_ack, flush all pointers to 0 and abort any segment in progress (init wins over a simultaneous in_sof).
REQ-035 SHALL on connected=0 flush pointers, go to IDLE and clear ack_pend and vout within 1 cycle, holding loc_ack.

Reset
REQ-036 SHALL on rst=0 at a clock edge set the state to IDLE, all pointers to 0, loc_ack=0, ack_pend=0, dup=0, vout=0, dout=0, and win=2^RAM_DEPTH-1 (4095 by default), regardless of the operation in progress.

Verification
REQ-037 SHALL check: init_ack=0x1000, then segment seq=0x1000 len=4 bytes AA BB CC DD no err -> loc_ack=0x1004, ack_pend=1, vout outputs AA BB CC DD on consecutive cycles.
REQ-038 SHALL check: segment seq=0x0FF0 len=8 -> dup pulses once, loc_ack unchanged, no vout.
REQ-039 SHALL check: segment len=6 with in_err=1 on eof -> loc_ack unchanged, no vout, win back to 4095 afterwards.
REQ-040 SHALL check: loc_ack=0xFFFFFFFE, then accepted len=4 -> loc_ack=0x00000002 (wrap).
REQ-041 SHALL check: with RAM_DEPTH=4 and 15 bytes buffered, a segment of len=1 -> DROP with no dup; pointers wrap correctly after the next drain.
REQ-042 SHALL check: rst=0 in mid-WRITE -> all outputs at reset values next cycle, and the next in-order segment is accepted normally.
